// File: rtl/vdp_video_timing_gen_if.sv
// Video pixel path between the VDP core, the timing generator and the board port.
// The generator takes the slave view: colour in, syncs/enable/blanked colour out.
interface vdp_video_timing_gen_if #(
    parameter int RGB_W = 6
);
    logic [RGB_W-1:0] r_i, g_i, b_i;
    logic             HS, VS, DE;
    logic [RGB_W-1:0] R, G, B;

    modport master (output r_i, g_i, b_i, input  HS, VS, DE, R, G, B);
    modport slave  (input  r_i, g_i, b_i, output HS, VS, DE, R, G, B);
endinterface

// File: rtl/vdp_video_timing_gen.sv
// Raster timing generator for the TMS9918-class VDP wrapper: HS/VS/DE, RGB blanking,
// NTSC/PAL line count switched only at frame wrap, line/frame strobes, beam counters.
module vdp_video_timing_gen #(
    parameter int CLK_DIV      = 2,
    parameter int H_TOTAL      = 342,
    parameter int H_SYNC       = 20,
    parameter int H_ACT_START  = 60,
    parameter int H_ACT_END    = 340,
    parameter int V_TOTAL_NTSC = 261,
    parameter int V_TOTAL_PAL  = 313,
    parameter int V_SYNC       = 4,
    parameter int V_ACT_START  = 8,
    parameter int H_INIT       = 0,
    parameter int SYNC_POL     = 0,
    parameter int RGB_W        = 6
) (
    input  logic                   clk,
    input  logic                   RESET,
    input  logic                   ena,
    input  logic                   pal_i,
    vdp_video_timing_gen_if.slave  vid,
    output logic [9:0]             hcnt_o,
    output logic [9:0]             vcnt_o,
    output logic                   pal_o,
    output logic                   line_start_o,
    output logic                   frame_start_o
);
    localparam int              DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [10:0]     H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0]     VN_LAST = 11'(V_TOTAL_NTSC - 1);
    localparam logic [10:0]     VP_LAST = 11'(V_TOTAL_PAL - 1);
    localparam logic [10:0]     HS_END  = 11'(H_SYNC);
    localparam logic [10:0]     VS_END  = 11'(V_SYNC);
    localparam logic [10:0]     HA_BEG  = 11'(H_ACT_START);
    localparam logic [10:0]     HA_END  = 11'(H_ACT_END);
    localparam logic [10:0]     VA_BEG  = 11'(V_ACT_START);
    localparam logic            SP      = (SYNC_POL != 0);

    logic             pal_meta_q, pal_sync_q;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [9:0]       hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic             pal_q, pal_d;
    logic             line_wrap_q, line_wrap_d, frame_wrap_q, frame_wrap_d;
    logic             hs_q, vs_q, de_q, line_start_q, frame_start_q;
    logic [RGB_W-1:0] r_q, g_q, b_q;
    logic [10:0]      h_ext, v_ext, vt_last;
    logic             active;

    // Mode request crosses in from an async source; no reset so it keeps tracking.
    always_ff @(posedge clk) begin
        pal_meta_q <= pal_i;
        pal_sync_q <= pal_meta_q;
    end

    assign h_ext   = {1'b0, hcnt_q};
    assign v_ext   = {1'b0, vcnt_q};
    assign vt_last = pal_q ? VP_LAST : VN_LAST;
    assign active  = (h_ext >= HA_BEG) && (h_ext <= HA_END) && (v_ext >= VA_BEG);

    always_comb begin
        div_cnt_d    = div_cnt_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        pal_d        = pal_q;
        line_wrap_d  = 1'b0;
        frame_wrap_d = 1'b0;
        if (ena) begin
            if (div_cnt_q == DIV_MAX) begin
                div_cnt_d = '0;
                if (h_ext == H_LAST) begin
                    hcnt_d      = '0;
                    line_wrap_d = 1'b1;
                    // >= also catches a line count left past the end of a shorter frame.
                    if (v_ext >= vt_last) begin
                        vcnt_d       = '0;
                        pal_d        = pal_sync_q;
                        frame_wrap_d = 1'b1;
                    end else begin
                        vcnt_d = vcnt_q + 10'd1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 10'd1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            div_cnt_q     <= '0;
            hcnt_q        <= 10'(H_INIT);
            vcnt_q        <= '0;
            pal_q         <= pal_sync_q;
            line_wrap_q   <= 1'b0;
            frame_wrap_q  <= 1'b0;
            hs_q          <= ~SP;
            vs_q          <= ~SP;
            de_q          <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            pal_q         <= pal_d;
            line_wrap_q   <= line_wrap_d;
            frame_wrap_q  <= frame_wrap_d;
            // Output stage sees the same counter state, so everything lands one clk later together.
            hs_q          <= (h_ext < HS_END) ~^ SP;
            vs_q          <= (v_ext < VS_END) ~^ SP;
            de_q          <= active;
            r_q           <= active ? vid.r_i : '0;
            g_q           <= active ? vid.g_i : '0;
            b_q           <= active ? vid.b_i : '0;
            line_start_q  <= line_wrap_q;
            frame_start_q <= frame_wrap_q;
        end
    end

    assign vid.HS        = hs_q;
    assign vid.VS        = vs_q;
    assign vid.DE        = de_q;
    assign vid.R         = r_q;
    assign vid.G         = g_q;
    assign vid.B         = b_q;
    assign hcnt_o        = hcnt_q;
    assign vcnt_o        = vcnt_q;
    assign pal_o         = pal_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
endmodule

// File: doc/vdp_video_timing_gen.md
Name: vdp_video_timing_gen

Overview:
- Parametrised raster timing generator and video output stage for the TMS9918-class VDP wrapper.
- Generates HS/VS/DE and zeroes the VDP RGB stream outside the active window.
- Adds a runtime-selectable NTSC/PAL line count, switched cleanly at frame boundaries, plus line/frame strobes and exposed beam counters.
- Sits between vdp18_core video outputs and the board video port, in the VDP clock domain.

Parameters:
- CLK_DIV, 2, number of enabled clocks (ena=1) per pixel; range 1..8.
- H_TOTAL, 342, pixels per line; hcnt runs 0..H_TOTAL-1.
- H_SYNC, 20, HS asserted while hcnt < H_SYNC.
- H_ACT_START, 60, first active pixel.
- H_ACT_END, 340, last active pixel, inclusive.
- V_TOTAL_NTSC, 261, lines per frame when NTSC.
- V_TOTAL_PAL, 313, lines per frame when PAL.
- V_SYNC, 4, VS asserted while vcnt < V_SYNC.
- V_ACT_START, 8, first active line; active through the last line of the frame.
- H_INIT, 0, hcnt value loaded at reset; must be less than H_TOTAL.
- SYNC_POL, 0, active level of HS/VS: 0 means active-low.
- RGB_W, 6, bits per colour channel.

Ports:
- clk  in  1  VDP clock
- RESET  in  1  synchronous, active-high reset
- ena  in  1  clock enable (10.7 MHz strobe)
- pal_i  in  1  mode request: 1 = PAL, 0 = NTSC; asynchronous source
- r_i, g_i, b_i  in  RGB_W each  pixel colour from the VDP core
- HS  out  1  horizontal sync, polarity set by SYNC_POL
- VS  out  1  vertical sync, polarity set by SYNC_POL
- DE  out  1  active-video enable
- R, G, B  out  RGB_W each  blanked colour
- hcnt_o  out  10  current pixel counter
- vcnt_o  out  10  current line counter
- pal_o  out  1  mode currently in effect
- line_start_o  out  1  one-clk pulse when hcnt wraps to 0
- frame_start_o  out  1  one-clk pulse when vcnt wraps to 0

Behaviour:
- Reset
  - Synchronous and active-high; has priority over ena.
  - On reset: div_cnt=0, hcnt=H_INIT, vcnt=0, pal_o=synced pal_i.
  - Outputs on reset: HS and VS at their inactive level; DE=0; R, G and B all 0; line_start_o=0 and frame_start_o=0.
- Mode input sync
  - pal_i passes through a 2-flop synchronizer (unaffected by reset).
- Pixel divider
  - When ena=1: if div_cnt==CLK_DIV-1, advance the pixel and load div_cnt=0; otherwise div_cnt+1.
  - When ena=0: div_cnt, hcnt and vcnt all hold.
- Pixel advance
  - If hcnt==H_TOTAL-1: hcnt=0 and vcnt advances; otherwise hcnt+1.
- Line wrap
  - Let VT=V_TOTAL_PAL when pal_o=1, else V_TOTAL_NTSC.
  - If vcnt==VT-1: vcnt=0 and pal_o is reloaded from synced pal_i. This is the only point where the mode changes outside reset.
  - Otherwise vcnt+1.
  - A pal_i toggle mid-frame never shortens or lengthens the current frame.
- Safety wrap
  - If vcnt is at or above the new VT, the next line advance forces vcnt=0.
- Output stage
  - All registered, updated every clk regardless of ena, and computed from current counter state and r/g/b_i. Latency is 1 clk relative to the counters, and all outputs are mutually aligned.
  - active = (hcnt ≥ H_ACT_START) and (hcnt ≤ H_ACT_END) and (vcnt ≥ V_ACT_START).
  - DE=active. R, G and B equal r/g/b_i when active, otherwise 0.
  - HS = (hcnt < H_SYNC) XNOR SYNC_POL; VS = (vcnt < V_SYNC) XNOR SYNC_POL.
- Strobes
  - line_start_o is registered and high for exactly one clk, the clk after hcnt becomes 0.
  - frame_start_o is high in the same clk as line_start_o when vcnt also became 0.
  - With CLK_DIV>1, the counters stay at 0 for several clks but each strobe still fires only once.
- Counter width
  - hcnt_o and vcnt_o are zero-extended to 10 bits; H_TOTAL and V_TOTAL_* must each be at most 1024.

Test Plan:
1. Reset and line period: RESET held 3 clks with ena=1, CLK_DIV=2, then released → first clk: HS=0 (active), DE=0, RGB=0. line_start_o pulses every 684 clks.
2. Frame period (NTSC): pal_i=0, ena=1 → frame_start_o period = 261×342×2 = 178,524 clks. VS is low for exactly 4 lines at the start of the frame.
3. PAL switch: raise pal_i at vcnt=100 → the current frame still ends at vcnt=260 and pal_o rises at the wrap. The next frame reaches vcnt=312 before wrapping; period 214,092 clks.
4. Blanking edges: r/g/b_i=6'h3F, vcnt=8 → R=0 for hcnt=59, 3F for hcnt=60 and 340, 0 for hcnt=341. R=0 everywhere on vcnt=7.
5. Enable gating: ena=0 for 50 clks mid-line → hcnt_o and vcnt_o frozen, outputs stable, no strobes. Counting resumes from the same value.
6. Reset mid-frame (vcnt=150, hcnt=200, H_INIT=5): assert RESET 1 clk → next clk hcnt_o=5 and vcnt_o=0. No frame_start_o pulse until the following frame wrap.
